// File: rtl/st_width_down_adapter_if.sv
// Avalon-ST link bundle; the same interface type serves the wide sink side and the narrow source side.
interface st_width_down_adapter_if #(
    parameter int DATA_W  = 8,
    parameter int EMPTY_W = 1
) ();
    logic               ready;
    logic               valid;
    logic [DATA_W-1:0]  data;
    logic               startofpacket;
    logic               endofpacket;
    logic [EMPTY_W-1:0] empty;
    logic               error;

    modport master (input ready, output valid, data, startofpacket, endofpacket, empty, error);
    modport slave (output ready, input valid, data, startofpacket, endofpacket, empty, error);
endinterface

// File: rtl/st_width_down_adapter.sv
// Avalon-ST width down-converter: splits each wide beat into IN_SYMBOLS/OUT_SYMBOLS narrow beats,
// MS symbol first, truncating the eop word according to its empty count.
module st_width_down_adapter #(
    parameter int SYMBOL_W    = 8,
    parameter int IN_SYMBOLS  = 4,
    parameter int OUT_SYMBOLS = 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    st_width_down_adapter_if.slave  in_i,
    st_width_down_adapter_if.master out_o
);
    localparam int RATIO = IN_SYMBOLS / OUT_SYMBOLS;
    localparam int IN_W  = SYMBOL_W * IN_SYMBOLS;
    localparam int OUT_W = SYMBOL_W * OUT_SYMBOLS;
    localparam int IEW   = (IN_SYMBOLS > 1) ? $clog2(IN_SYMBOLS) : 1;
    localparam int OEW   = (OUT_SYMBOLS > 1) ? $clog2(OUT_SYMBOLS) : 1;
    localparam int KW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int CW    = $clog2(IN_SYMBOLS + OUT_SYMBOLS) + 1;

    if (IN_SYMBOLS % OUT_SYMBOLS != 0) begin : g_bad_ratio
        $error("IN_SYMBOLS must be an integer multiple of OUT_SYMBOLS");
    end

    // Holding register A and slice counter
    logic             a_valid_q, a_valid_d;
    logic [IN_W-1:0]  a_data_q, a_data_d;
    logic             a_sop_q, a_sop_d;
    logic             a_eop_q, a_eop_d;
    logic [IEW-1:0]   a_empty_q, a_empty_d;
    logic             a_error_q, a_error_d;
    logic [KW-1:0]    k_q, k_d;

    // Output register stage
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic             out_sop_q, out_sop_d;
    logic             out_eop_q, out_eop_d;
    logic [OEW-1:0]   out_empty_q, out_empty_d;
    logic             out_error_q, out_error_d;

    logic [CW-1:0]    emp_c, v_c, nslice_c, pad_c;
    logic [KW-1:0]    last_k_c;
    logic             out_load_c, adv_c, is_last_c, in_ready_c;
    logic [IN_W-1:0]  shifted_c;
    logic [OUT_W-1:0] slice_c;

    always_comb begin
        // NOTE: every signal assigned here gets a default on entry, so no path can infer a latch.
        emp_c = CW'(a_empty_q);
        if (emp_c > CW'(IN_SYMBOLS - 1)) emp_c = CW'(IN_SYMBOLS - 1);
        v_c      = CW'(IN_SYMBOLS) - emp_c;
        nslice_c = (v_c + CW'(OUT_SYMBOLS - 1)) / CW'(OUT_SYMBOLS);
        pad_c    = nslice_c * CW'(OUT_SYMBOLS) - v_c;
        last_k_c = a_eop_q ? KW'(nslice_c - CW'(1)) : KW'(RATIO - 1);

        out_load_c = out_o.ready || !out_valid_q;
        adv_c      = a_valid_q && out_load_c;
        is_last_c  = (k_q == last_k_c);
        in_ready_c = !a_valid_q || (adv_c && is_last_c);

        shifted_c = a_data_q << (int'(k_q) * OUT_W);
        slice_c   = shifted_c[IN_W-1 -: OUT_W];

        a_valid_d = a_valid_q;
        a_data_d  = a_data_q;
        a_sop_d   = a_sop_q;
        a_eop_d   = a_eop_q;
        a_empty_d = a_empty_q;
        a_error_d = a_error_q;
        if (in_ready_c) begin
            a_valid_d = in_i.valid;
            if (in_i.valid) begin
                a_data_d  = in_i.data;
                a_sop_d   = in_i.startofpacket;
                a_eop_d   = in_i.endofpacket;
                a_empty_d = in_i.endofpacket ? in_i.empty : '0;
                a_error_d = in_i.error;
            end
        end

        // Reaching the last valid slice skips any padding slices of a truncated word.
        k_d = k_q;
        if (adv_c) k_d = is_last_c ? '0 : k_q + KW'(1);

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        out_empty_d = out_empty_q;
        out_error_d = out_error_q;
        if (out_load_c) begin
            out_valid_d = adv_c;
            out_data_d  = adv_c ? slice_c : '0;
            out_sop_d   = adv_c && a_sop_q && (k_q == '0);
            out_eop_d   = adv_c && a_eop_q && is_last_c;
            out_empty_d = (adv_c && a_eop_q && is_last_c) ? OEW'(pad_c) : '0;
            out_error_d = adv_c && a_error_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_valid_q   <= 1'b0;
            a_data_q    <= '0;
            a_sop_q     <= 1'b0;
            a_eop_q     <= 1'b0;
            a_empty_q   <= '0;
            a_error_q   <= 1'b0;
            k_q         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_empty_q <= '0;
            out_error_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
            a_valid_q   <= a_valid_d;
            a_data_q    <= a_data_d;
            a_sop_q     <= a_sop_d;
            a_eop_q     <= a_eop_d;
            a_empty_q   <= a_empty_d;
            a_error_q   <= a_error_d;
            k_q         <= k_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            out_empty_q <= out_empty_d;
            out_error_q <= out_error_d;
        end
    end

    assign in_i.ready          = in_ready_c;
    assign out_o.valid         = out_valid_q;
    assign out_o.data          = out_data_q;
    assign out_o.startofpacket = out_sop_q;
    assign out_o.endofpacket   = out_eop_q;
    assign out_o.empty         = out_empty_q;
    assign out_o.error         = out_error_q;
endmodule

// File: tb/tb_st_width_down_adapter.sv
// Scoreboard bench for st_width_down_adapter: three instances (8/4/1, 8/8/2, 8/4/4) driven with
// directed words; a monitor pops hand-computed expected beats and also checks stall stability.
module tb_st_width_down_adapter;
    typedef struct {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  empty;
        logic        error;
    } exp_t;

    logic clk;
    logic reset_n;
    bit   toggle_en;
    int   checks;
    int   failures;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    bit   stall[3];
    exp_t snap[3];

    st_width_down_adapter_if #(.DATA_W(32), .EMPTY_W(2)) i0 ();
    st_width_down_adapter_if #(.DATA_W(8),  .EMPTY_W(1)) o0 ();
    st_width_down_adapter_if #(.DATA_W(64), .EMPTY_W(3)) i1 ();
    st_width_down_adapter_if #(.DATA_W(16), .EMPTY_W(1)) o1 ();
    st_width_down_adapter_if #(.DATA_W(32), .EMPTY_W(2)) i2 ();
    st_width_down_adapter_if #(.DATA_W(32), .EMPTY_W(2)) o2 ();

    st_width_down_adapter #(.SYMBOL_W(8), .IN_SYMBOLS(4), .OUT_SYMBOLS(1)) u0 (
        .clk(clk), .reset_n(reset_n), .in_i(i0), .out_o(o0));
    st_width_down_adapter #(.SYMBOL_W(8), .IN_SYMBOLS(8), .OUT_SYMBOLS(2)) u1 (
        .clk(clk), .reset_n(reset_n), .in_i(i1), .out_o(o1));
    st_width_down_adapter #(.SYMBOL_W(8), .IN_SYMBOLS(4), .OUT_SYMBOLS(4)) u2 (
        .clk(clk), .reset_n(reset_n), .in_i(i2), .out_o(o2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    task automatic push(input int id, input logic [63:0] d, input logic s, input logic e,
                        input logic [2:0] em, input logic er);
        exp_t x;
        x.data = d; x.sop = s; x.eop = e; x.empty = em; x.error = er;
        case (id)
            0: q0.push_back(x);
            1: q1.push_back(x);
            default: q2.push_back(x);
        endcase
    endtask

    function automatic int qsize(input int id);
        case (id)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t qpop(input int id);
        case (id)
            0: return q0.pop_front();
            1: return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    function automatic exp_t cur(input int id);
        exp_t a;
        case (id)
            0: begin a.data = 64'(o0.data); a.sop = o0.startofpacket; a.eop = o0.endofpacket;
                     a.empty = 3'(o0.empty); a.error = o0.error; end
            1: begin a.data = 64'(o1.data); a.sop = o1.startofpacket; a.eop = o1.endofpacket;
                     a.empty = 3'(o1.empty); a.error = o1.error; end
            default: begin a.data = 64'(o2.data); a.sop = o2.startofpacket; a.eop = o2.endofpacket;
                     a.empty = 3'(o2.empty); a.error = o2.error; end
        endcase
        return a;
    endfunction

    function automatic logic out_valid(input int id);
        case (id)
            0: return o0.valid;
            1: return o1.valid;
            default: return o2.valid;
        endcase
    endfunction

    function automatic logic out_ready(input int id);
        case (id)
            0: return o0.ready;
            1: return o1.ready;
            default: return o2.ready;
        endcase
    endfunction

    function automatic logic in_ready(input int id);
        case (id)
            0: return i0.ready;
            1: return i1.ready;
            default: return i2.ready;
        endcase
    endfunction

    task automatic cmp_beat(input string name, input exp_t a, input exp_t e);
        check({name, "_data"}, a.data, e.data);
        check({name, "_sop_eop_empty_err"}, 64'({a.sop, a.eop, a.empty, a.error}),
              64'({e.sop, e.eop, e.empty, e.error}));
    endtask

    // Beats are sampled on the falling edge; valid&&ready there means transfer at the next rising edge.
    task automatic mon_step(input int id);
        exp_t a;
        exp_t e;
        logic v;
        logic r;
        a = cur(id);
        v = out_valid(id);
        r = out_ready(id);
        if (!reset_n) begin
            stall[id] = 1'b0;
            return;
        end
        if (stall[id]) begin
            check($sformatf("u%0d_hold_valid", id), 64'(v), 64'(1));
            cmp_beat($sformatf("u%0d_hold", id), a, snap[id]);
        end
        stall[id] = v && !r;
        snap[id]  = a;
        if (v && r) begin
            if (qsize(id) == 0) fail_now($sformatf("u%0d_unexpected_beat data=%h", id, a.data));
            else begin
                e = qpop(id);
                cmp_beat($sformatf("u%0d_beat", id), a, e);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            mon_step(0);
            mon_step(1);
            mon_step(2);
        end
    end

    // u0 sink readiness changes only mid-high-phase so the monitor and driver see settled values.
    initial begin
        o0.ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (toggle_en) o0.ready = ~o0.ready;
            else o0.ready = 1'b1;
        end
    end

    // Called just after a falling edge with the beat already driven; returns just after the next one.
    task automatic accept_wait(input int id, output int tries);
        logic rdy;
        tries = 0;
        rdy = 1'b0;
        while (!rdy && tries < 64) begin
            #4;
            rdy = in_ready(id);
            tries++;
            @(posedge clk);
            if (!rdy) @(negedge clk);
        end
        @(negedge clk);
        if (!rdy) fail_now($sformatf("u%0d_accept_timeout", id));
    endtask

    task automatic send0(input logic [31:0] d, input logic s, input logic e, input logic [1:0] em,
                         input logic er, output int tries);
        i0.valid = 1'b1; i0.data = d; i0.startofpacket = s; i0.endofpacket = e;
        i0.empty = em; i0.error = er;
        accept_wait(0, tries);
        i0.valid = 1'b0;
    endtask

    task automatic send1(input logic [63:0] d, input logic s, input logic e, input logic [2:0] em,
                         input logic er, output int tries);
        i1.valid = 1'b1; i1.data = d; i1.startofpacket = s; i1.endofpacket = e;
        i1.empty = em; i1.error = er;
        accept_wait(1, tries);
        i1.valid = 1'b0;
    endtask

    task automatic send2(input logic [31:0] d, input logic s, input logic e, input logic [1:0] em,
                         input logic er, output int tries);
        i2.valid = 1'b1; i2.data = d; i2.startofpacket = s; i2.endofpacket = e;
        i2.empty = em; i2.error = er;
        accept_wait(2, tries);
        i2.valid = 1'b0;
    endtask

    task automatic wait_drain(input int id);
        for (int n = 0; n < 200; n++) begin
            if (qsize(id) == 0) break;
            @(negedge clk);
        end
        check($sformatf("u%0d_drained", id), 64'(qsize(id)), 64'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int t;
        checks = 0;
        failures = 0;
        toggle_en = 1'b0;
        reset_n = 1'b0;
        i0.valid = 1'b0; i0.data = '0; i0.startofpacket = 1'b0; i0.endofpacket = 1'b0;
        i0.empty = '0; i0.error = 1'b0;
        i1.valid = 1'b0; i1.data = '0; i1.startofpacket = 1'b0; i1.endofpacket = 1'b0;
        i1.empty = '0; i1.error = 1'b0;
        i2.valid = 1'b0; i2.data = '0; i2.startofpacket = 1'b0; i2.endofpacket = 1'b0;
        i2.empty = '0; i2.error = 1'b0;
        o1.ready = 1'b1;
        o2.ready = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_u0_out", 64'({o0.valid, o0.data, o0.startofpacket, o0.endofpacket, o0.empty, o0.error}), 64'(0));
        check("rst_u1_out_valid", 64'(o1.valid), 64'(0));
        check("rst_u2_out_valid", 64'(o2.valid), 64'(0));
        check("rst_u0_in_ready", 64'(i0.ready), 64'(1));
        reset_n = 1'b1;
        @(negedge clk);

        // Two plain words under continuous ready: one slice per cycle, a word every 4 cycles.
        push(0, 64'h11, 0, 0, 0, 0); push(0, 64'h22, 0, 0, 0, 0);
        push(0, 64'h33, 0, 0, 0, 0); push(0, 64'h44, 0, 0, 0, 0);
        push(0, 64'h55, 0, 0, 0, 0); push(0, 64'h66, 0, 0, 0, 0);
        push(0, 64'h77, 0, 0, 0, 0); push(0, 64'h88, 0, 0, 0, 0);
        send0(32'h11223344, 0, 0, 2'd0, 0, t);
        check("t1_no_output_before_e1", 64'(o0.valid), 64'(0));
        send0(32'h55667788, 0, 0, 2'd0, 0, t);
        check("t1_accept_spacing", 64'(t), 64'(4));

        // Single-beat packet truncated to 2 symbols, next word follows with no bubble.
        push(0, 64'hAA, 1, 0, 0, 0); push(0, 64'hBB, 0, 1, 0, 0);
        push(0, 64'h01, 0, 0, 0, 0); push(0, 64'h02, 0, 0, 0, 0);
        push(0, 64'h03, 0, 0, 0, 0); push(0, 64'h04, 0, 0, 0, 0);
        send0(32'hAABBCCDD, 1, 1, 2'd2, 0, t);
        send0(32'h01020304, 0, 0, 2'd0, 0, t);
        check("t2_accept_after_truncated", 64'(t), 64'(2));
        wait_drain(0);

        // Stalls every other cycle; error on exactly the second word's slices.
        toggle_en = 1'b1;
        push(0, 64'hA1, 1, 0, 0, 0); push(0, 64'hA2, 0, 0, 0, 0);
        push(0, 64'hA3, 0, 0, 0, 0); push(0, 64'hA4, 0, 0, 0, 0);
        push(0, 64'hB1, 0, 0, 0, 1); push(0, 64'hB2, 0, 0, 0, 1);
        push(0, 64'hB3, 0, 0, 0, 1); push(0, 64'hB4, 0, 1, 0, 1);
        send0(32'hA1A2A3A4, 1, 0, 2'd0, 0, t);
        send0(32'hB1B2B3B4, 0, 1, 2'd0, 1, t);
        wait_drain(0);
        toggle_en = 1'b0;
        repeat (3) @(negedge clk);

        // Reset after two slices: remaining slices are dropped and nothing is captured during reset.
        push(0, 64'hDE, 1, 0, 0, 0); push(0, 64'hAD, 0, 0, 0, 0);
        send0(32'hDEADBEEF, 1, 0, 2'd0, 0, t);
        @(negedge clk);
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("t5_rst_out", 64'({o0.valid, o0.data, o0.startofpacket, o0.endofpacket, o0.empty, o0.error}), 64'(0));
        check("t5_rst_in_ready", 64'(i0.ready), 64'(1));
        i0.valid = 1'b1; i0.data = 32'hFFFFFFFF;
        @(negedge clk);
        @(negedge clk);
        i0.valid = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        push(0, 64'h01, 1, 0, 0, 0); push(0, 64'h02, 0, 0, 0, 0);
        push(0, 64'h03, 0, 0, 0, 0); push(0, 64'h04, 0, 1, 0, 0);
        send0(32'h01020304, 1, 1, 2'd0, 0, t);
        wait_drain(0);

        // 8 -> 2 symbols: empty ignored without eop, eop with empty=3 gives 3 beats, last padded by 1.
        push(1, 64'h1112, 1, 0, 0, 0); push(1, 64'h1314, 0, 0, 0, 0);
        push(1, 64'h1516, 0, 0, 0, 0); push(1, 64'h1718, 0, 0, 0, 0);
        push(1, 64'h0102, 0, 0, 0, 0); push(1, 64'h0304, 0, 0, 0, 0);
        push(1, 64'h0506, 0, 1, 3'd1, 0);
        push(1, 64'hA1A2, 1, 0, 0, 0); push(1, 64'hA3A4, 0, 0, 0, 0);
        push(1, 64'hA5A6, 0, 0, 0, 0); push(1, 64'hA7A8, 0, 1, 3'd0, 0);
        send1(64'h1112131415161718, 1, 0, 3'd5, 0, t);
        send1(64'h0102030405060708, 0, 1, 3'd3, 0, t);
        check("t3_accept_full_word", 64'(t), 64'(4));
        send1(64'hA1A2A3A4A5A6A7A8, 1, 1, 3'd0, 0, t);
        check("t3_accept_after_3_slices", 64'(t), 64'(3));
        wait_drain(1);

        // Pass-through ratio: beats unchanged, empty kept only on eop.
        push(2, 64'h10203040, 1, 0, 0, 0);
        push(2, 64'h50607080, 0, 0, 0, 0);
        push(2, 64'h90A0B0C0, 0, 1, 3'd1, 0);
        send2(32'h10203040, 1, 0, 2'd0, 0, t);
        send2(32'h50607080, 0, 0, 2'd3, 0, t);
        check("t6_accept_every_cycle", 64'(t), 64'(1));
        send2(32'h90A0B0C0, 0, 1, 2'd1, 0, t);
        wait_drain(2);

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
